// File: rtl/vram_cpu_port.sv
// Shared 8 KB video RAM: display reads have priority, CPU writes are queued in a FIFO.
// Define VRAM_CLEAR_EN to add the fill-all-memory clear engine.
module vram_cpu_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        disp_fetch,
  input  logic [12:0] disp_addr,
  output logic [7:0]  disp_data
`ifdef VRAM_CLEAR_EN
  ,
  input  logic        clr_start,
  input  logic [7:0]  clr_value,
  output logic        clr_busy
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, DRAIN, RD_ISSUE, RD_DATA
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  ram_q [4][2048];
  logic [12:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]  fifo_data_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic        rd_pending_q, rd_pending_d;
  logic [12:0] rd_addr_q;
  logic [7:0]  rdata_q, disp_data_q;
  logic        rvalid_q;

  logic fifo_full, fifo_empty, empty_d;
  logic push, rd_acc, pop, rd_issue, stall;
  logic clearing, clr_we;
  logic [12:0] clr_addr;
  logic [7:0]  clr_val;
  logic        ram_we;
  logic [12:0] ram_waddr;
  logic [7:0]  ram_wdata;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign cpu_ready = !fifo_full && !rd_pending_q && !clearing;
  assign push      = cpu_req && cpu_ready && cpu_we;
  assign rd_acc    = cpu_req && cpu_ready && !cpu_we;
  assign stall     = disp_fetch || clearing;

  assign wr_ptr_d     = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d     = rd_ptr_q + {{PW{1'b0}}, pop};
  assign empty_d      = (wr_ptr_d == rd_ptr_d);
  assign rd_pending_d = (rd_pending_q && !rd_issue) || rd_acc;

`ifdef VRAM_CLEAR_EN
  logic        clr_busy_q;
  logic [12:0] clr_addr_q;
  logic [7:0]  clr_val_q;
  logic        clr_go;

  // Only start from a fully quiet port so no CPU traffic is interleaved.
  assign clr_go = clr_start && !clr_busy_q && (state_q == IDLE) &&
                  fifo_empty && !rd_pending_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_busy_q <= 1'b0;
      clr_addr_q <= '0;
      clr_val_q  <= '0;
    end else if (clr_go) begin
      clr_busy_q <= 1'b1;
      clr_addr_q <= '0;
      clr_val_q  <= clr_value;
    end else if (clr_we) begin
      clr_addr_q <= clr_addr_q + 13'd1;
      if (clr_addr_q == 13'h1FFF) clr_busy_q <= 1'b0;
    end
  end

  assign clearing = clr_busy_q;
  assign clr_we   = clr_busy_q && !disp_fetch;
  assign clr_addr = clr_addr_q;
  assign clr_val  = clr_val_q;
  assign clr_busy = clr_busy_q;
`else
  assign clearing = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign clr_val  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        RD_ISSUE: state_d = RD_DATA;
        default: begin
          if (!empty_d)          state_d = DRAIN;
          else if (rd_pending_d) state_d = RD_ISSUE;
          else                   state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pop      = (state_q == DRAIN) && !stall;
    rd_issue = (state_q == RD_ISSUE) && !stall;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fifo_addr_q[rd_ptr_q[PW-1:0]];
    ram_wdata = fifo_data_q[rd_ptr_q[PW-1:0]];
    unique case (1'b1)
      clr_we: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = clr_val;
      end
      pop:     ram_we = 1'b1;
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr[12:11]][ram_waddr[10:0]] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PW-1:0]] <= cpu_addr;
      fifo_data_q[wr_ptr_q[PW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
      rvalid_q     <= rd_issue;
      if (rd_acc)     rd_addr_q <= cpu_addr;
      if (rd_issue)   rdata_q <= ram_q[rd_addr_q[12:11]][rd_addr_q[10:0]];
      if (disp_fetch) disp_data_q <= ram_q[disp_addr[12:11]][disp_addr[10:0]];
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Scoreboard bench for vram_cpu_port: directed CPU/display traffic,
// queued expectations checked by an independent monitor.
module tb_vram_cpu_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        disp_fetch = 1'b0;
  logic [12:0] disp_addr = '0;
  logic [7:0]  disp_data;
`ifdef VRAM_CLEAR_EN
  logic        clr_start = 1'b0;
  logic [7:0]  clr_value = '0;
  logic        clr_busy;
`endif

  vram_cpu_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .disp_fetch(disp_fetch), .disp_addr(disp_addr),
    .disp_data(disp_data)
`ifdef VRAM_CLEAR_EN
    , .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  rd_exp_t    rdq[$];
  logic [7:0] dispq[$];
  logic [7:0] disp_exp = '0;
  logic       fetch_q = 1'b0;
  rd_exp_t    m_e;
  logic [7:0] m_d;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    fetch_q <= disp_fetch;
    if (disp_fetch) dispq.push_back(disp_exp);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor: compares every DUT response against the queued expectation.
  always @(negedge clk) begin
    if (reset_n && cpu_rvalid) begin
      if (rdq.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        m_e = rdq.pop_front();
        chk("rd_data", int'(cpu_rdata), int'(m_e.data));
        if (m_e.cyc >= 0) chk("rd_latency", cyc, m_e.cyc);
      end
    end
    if (reset_n && fetch_q) begin
      if (dispq.size() == 0) begin
        chk("disp_unexpected", 1, 0);
      end else begin
        m_d = dispq.pop_front();
        chk("disp_data", int'(disp_data), int'(m_d));
      end
    end
  end

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
    int   n;
    logic acc;
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    do begin
      @(negedge clk); acc = cpu_ready; n++;
      @(posedge clk);
    end while (!acc && n < 60);
    #1 cpu_req = 1'b0; cpu_we = 1'b0;
    if (!acc) chk("wr_timeout", 0, 1);
  endtask

  task automatic cpu_read(input logic [12:0] a, input logic [7:0] e,
                          input bit lat);
    int      n;
    int      acyc;
    logic    acc;
    rd_exp_t x;
    n = 0; acyc = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    do begin
      @(negedge clk); acc = cpu_ready; acyc = cyc; n++;
      @(posedge clk);
    end while (!acc && n < 60);
    #1 cpu_req = 1'b0;
    if (!acc) begin
      chk("rd_timeout", 0, 1);
    end else begin
      x.data = e;
      x.cyc  = lat ? acyc + 2 : -1;
      rdq.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_done();
    int n;
    n = 0;
    while (rdq.size() > 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    chk("rd_drained", rdq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(cpu_ready), 1);
    chk("rst_rvalid", int'(cpu_rvalid), 0);
    chk("rst_rdata", int'(cpu_rdata), 0);
    chk("rst_disp", int'(disp_data), 0);
    @(posedge clk); #1;

    // T1: write then read, minimum read latency
    cpu_write(13'h0123, 8'hA5);
    cpu_read(13'h0123, 8'hA5, 1'b1);
    wait_rd_done();

    cpu_write(13'h0028, 8'h5A);
    cpu_write(13'h1800, 8'h11);
    idle(3);
    disp_exp = 8'h5A;
    disp_addr = 13'h0028;

    // T2: FIFO fills while display holds the RAM
    disp_fetch = 1'b1;
    cpu_write(13'h0100, 8'h10);
    cpu_write(13'h0101, 8'h11);
    cpu_write(13'h0102, 8'h12);
    cpu_write(13'h0103, 8'h13);
    @(negedge clk);
    chk("t2_full_ready", int'(cpu_ready), 0);
    @(posedge clk); #1;
    fork
      cpu_write(13'h0100, 8'h15);
      begin
        idle(2);
        @(negedge clk);
        chk("t2_still_full", int'(cpu_ready), 0);
        @(posedge clk); #1 disp_fetch = 1'b0;
      end
    join
    cpu_read(13'h0100, 8'h15, 1'b0);
    cpu_read(13'h0101, 8'h11, 1'b0);
    cpu_read(13'h0102, 8'h12, 1'b0);
    cpu_read(13'h0103, 8'h13, 1'b0);
    wait_rd_done();

    // T3: read while the write to the same address is still queued
    disp_fetch = 1'b1;
    cpu_write(13'h1800, 8'h3C);
    disp_fetch = 1'b0;
    cpu_read(13'h1800, 8'h3C, 1'b0);
    wait_rd_done();

    // T4: periodic display fetch against streaming CPU writes
    fork
      for (int i = 0; i < 6; i++) begin
        disp_fetch = 1'b1;
        @(posedge clk); #1 disp_fetch = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 10; i++)
        cpu_write(13'h0200 + 13'(i), 8'h80 + 8'(i));
    join
    @(negedge clk);
    chk("t4_disp_hold", int'(disp_data), 8'h5A);
    @(posedge clk); #1;
    cpu_read(13'h0200, 8'h80, 1'b0);
    cpu_read(13'h0209, 8'h89, 1'b0);
    cpu_read(13'h0028, 8'h5A, 1'b0);
    wait_rd_done();

    // T5: reset discards queued writes
    cpu_write(13'h0300, 8'h31);
    cpu_write(13'h0301, 8'h32);
    cpu_write(13'h0302, 8'h33);
    idle(3);
    disp_fetch = 1'b1;
    cpu_write(13'h0300, 8'hE0);
    cpu_write(13'h0301, 8'hE1);
    cpu_write(13'h0302, 8'hE2);
    disp_fetch = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("t5_ready", int'(cpu_ready), 1);
    chk("t5_rvalid", int'(cpu_rvalid), 0);
    chk("t5_disp_rst", int'(disp_data), 0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    cpu_read(13'h0300, 8'h31, 1'b1);
    cpu_read(13'h0301, 8'h32, 1'b0);
    cpu_read(13'h0302, 8'h33, 1'b0);
    wait_rd_done();

`ifdef VRAM_CLEAR_EN
    // T6: clear engine fills the whole RAM
    begin
      int n;
      n = 0;
      clr_value = 8'hFF; clr_start = 1'b1;
      @(posedge clk); #1 clr_start = 1'b0;
      @(negedge clk);
      chk("t6_busy", int'(clr_busy), 1);
      chk("t6_ready", int'(cpu_ready), 0);
      while (clr_busy && n < 9000) begin
        n++; @(negedge clk);
      end
      chk("t6_cycles", int'(n >= 8192 && !clr_busy), 1);
      @(posedge clk); #1;
      cpu_read(13'h0000, 8'hFF, 1'b1);
      cpu_read(13'h07FF, 8'hFF, 1'b0);
      cpu_read(13'h1FFF, 8'hFF, 1'b0);
      wait_rd_done();
    end
`endif

    idle(4);
    chk("disp_drained", dispq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
